// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_if.sv
// Instruction-ROM read port: fetch stage drives address/enable/flush, ROM returns
// registered read data one cycle later.
interface fetch_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] addr;
  logic             en;
  logic             flush;
  logic [WIDTH-1:0] rd;

  modport master (output addr, output en, output flush, input rd);
  modport slave  (input addr, input en, input flush, output rd);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM port, and pairs the ROM's
// registered output with the PC it was fetched from.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               LENGTH   = 256,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] NOP      = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  fetch_if.master          imem,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus4_o,
  output logic             valid_o,
  output logic             fault_o
);

  // One extra bit so LENGTH*4 never aliases when it equals 2^WIDTH.
  localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(LENGTH * INSTR_BYTES);

  fetch_state_t     r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_pc_d;
  logic             r_valid;

  logic w_fault_now;
  logic w_fetch;

  assign w_fault_now = (r_pc[1:0] != 2'b00) | ({1'b0, r_pc} >= LIMIT);
  assign w_fetch     = (r_state != FAULT) & ~stall_i & ~redirect_i & ~w_fault_now;

  // NOTE: the ROM port is gated by rst_n so no read or clear is issued while reset
  // is held; the registers alone cannot guarantee that because reset is async.
  assign imem.addr  = r_pc;
  assign imem.en    = w_fetch & rst_n;
  assign imem.flush = redirect_i & (r_state != FAULT) & rst_n;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
    end else begin
      case (r_state)
        BOOT:    r_state <= RUN;
        RUN:     if (w_fault_now) r_state <= FAULT;
        FAULT:   r_state <= FAULT;
        default: r_state <= BOOT;
      endcase
    end
  end

  // A fault in RUN beats a redirect; FAULT ignores everything until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_pc_d  <= '0;
      r_valid <= 1'b0;
    end else if ((r_state == RUN) && w_fault_now) begin
      r_valid <= 1'b0;
    end else if (r_state != FAULT) begin
      if (redirect_i) begin
        r_pc    <= redirect_pc_i;
        r_pc_d  <= '0;
        r_valid <= 1'b0;
      end else if (w_fetch) begin
        r_pc_d  <= r_pc;
        r_pc    <= r_pc + WIDTH'(INSTR_BYTES);
        r_valid <= 1'b1;
      end
    end
  end

  assign valid_o    = r_valid & (r_state == RUN);
  assign instr_o    = valid_o ? imem.rd : NOP;
  assign pc_o       = r_pc_d;
  assign pc_plus4_o = r_pc_d + WIDTH'(INSTR_BYTES);
  assign fault_o    = (r_state == FAULT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural ROM (rom[i] = A000_0000 + i), directed
// scenarios, then randomized stall/redirect/reset traffic against a PC-level model.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;
  logic        fault_o;

  fetch_if #(.WIDTH(32)) imem ();

  fetch_stage #(
    .WIDTH(32), .LENGTH(256), .RESET_PC(32'h0), .NOP(32'h0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (imem),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .valid_o       (valid_o),
    .fault_o       (fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 1-cycle ROM with enable and synchronous clear; contents never reset.
  logic [31:0] rom [0:255];
  initial for (int i = 0; i < 256; i++) rom[i] = 32'hA000_0000 + 32'(i);
  always @(posedge clk) begin
    if (imem.flush)   imem.rd <= 32'h0;
    else if (imem.en) imem.rd <= rom[imem.addr[9:2]];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: next fetch address, the PC currently presented, and sticky status.
  logic [31:0] m_pc;
  logic [31:0] m_pc_out;
  bit          m_valid;
  bit          m_fault;
  bit          m_boot;

  function automatic bit bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'd1024);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_pc_out = 32'h0; m_valid = 0; m_fault = 0; m_boot = 1;
  endtask

  task automatic model_step(input bit s, input bit r, input logic [31:0] t);
    if (m_fault) begin
    end else if (!m_boot && bad_addr(m_pc)) begin
      m_fault = 1; m_valid = 0;
    end else if (r) begin
      m_pc = t; m_valid = 0; m_pc_out = 32'h0;
    end else if (!s && !bad_addr(m_pc)) begin
      m_pc_out = m_pc; m_valid = 1; m_pc = m_pc + 32'd4;
    end
    m_boot = 0;
  endtask

  task automatic check_outputs();
    bit ev;
    ev = m_valid && !m_fault;
    check("valid_o", 32'(valid_o), 32'(ev));
    check("instr_o", instr_o, ev ? 32'hA000_0000 + (m_pc_out >> 2) : 32'h0);
    check("pc_o", pc_o, m_pc_out);
    check("pc_plus4_o", pc_plus4_o, m_pc_out + 32'd4);
    check("fault_o", 32'(fault_o), 32'(m_fault));
  endtask

  // One clock: drive inputs at negedge, check ROM port, advance, check outputs.
  task automatic cycle(input bit s, input bit r, input logic [31:0] t);
    @(negedge clk);
    stall_i = s; redirect_i = r; redirect_pc_i = t;
    #1;
    check("imem_addr", imem.addr, m_pc);
    check("imem_en", 32'(imem.en), 32'(!m_fault && !s && !r && !bad_addr(m_pc)));
    check("imem_flush", 32'(imem.flush), 32'(r && !m_fault));
    @(posedge clk);
    model_step(s, r, t);
    #2;
    check_outputs();
  endtask

  task automatic do_reset();
    stall_i = 1'b0; redirect_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_en", 32'(imem.en), 32'h0);
    check("rst_flush", 32'(imem.flush), 32'h0);
    check("rst_fault", 32'(fault_o), 32'h0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_addr", imem.addr, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  bit          s_r, r_r;
  logic [31:0] t_r;
  int          sel;

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    model_reset();
    do_reset();

    // Sequential fetch after reset, then a 3-cycle stall at pc 8.
    cycle(0, 0, 0); check("s1_pc0", pc_o, 32'h0); check("s1_i0", instr_o, 32'hA000_0000);
    check("s1_v0", 32'(valid_o), 32'h1);
    cycle(0, 0, 0); check("s1_pc4", pc_o, 32'h4); check("s1_i1", instr_o, 32'hA000_0001);
    cycle(0, 0, 0); check("s1_pc8", pc_o, 32'h8); check("s1_i2", instr_o, 32'hA000_0002);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 0);
      check("s2_pc", pc_o, 32'h8); check("s2_i", instr_o, 32'hA000_0002);
      check("s2_v", 32'(valid_o), 32'h1);
    end
    cycle(0, 0, 0); check("s2_pc12", pc_o, 32'hC); check("s2_i3", instr_o, 32'hA000_0003);

    // Redirect to 0x40; then redirect together with stall to 0x20.
    cycle(0, 1, 32'h40); check("s3_v", 32'(valid_o), 32'h0); check("s3_nop", instr_o, 32'h0);
    cycle(0, 0, 0); check("s3_pc", pc_o, 32'h40); check("s3_i", instr_o, 32'hA000_0010);
    cycle(1, 1, 32'h20); check("s4_v", 32'(valid_o), 32'h0);
    cycle(0, 0, 0); check("s4_pc", pc_o, 32'h20); check("s4_i", instr_o, 32'hA000_0008);

    // Last word of the ROM, then an out-of-range fetch that faults.
    cycle(0, 1, 32'h3FC);
    cycle(0, 0, 0); check("s5_pc", pc_o, 32'h3FC); check("s5_i", instr_o, 32'hA000_00FF);
    cycle(0, 0, 0); check("s5_fault", 32'(fault_o), 32'h1); check("s5_v", 32'(valid_o), 32'h0);
    cycle(0, 1, 32'h0); cycle(1, 0, 0); cycle(0, 0, 0);
    check("s5_addr", imem.addr, 32'h400);
    do_reset();
    cycle(0, 0, 0); check("s5_restart", instr_o, 32'hA000_0000);

    // Misaligned redirect, then async reset mid-stream.
    cycle(0, 1, 32'h22); check("s6_nofault", 32'(fault_o), 32'h0);
    cycle(0, 0, 0); check("s6_fault", 32'(fault_o), 32'h1);
    repeat (3) cycle(0, 0, 0);
    do_reset();
    repeat (4) cycle(0, 0, 0);
    do_reset();

    for (int i = 0; i < 1500; i++) begin
      if ((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) do_reset();
      s_r = ($urandom_range(0, 3) == 0);
      r_r = ($urandom_range(0, 7) == 0);
      sel = int'($urandom_range(0, 15));
      case (sel)
        0:       t_r = {22'h0, 8'($urandom), 2'($urandom_range(1, 3))};
        1:       t_r = 32'h400 + {20'h0, 10'($urandom), 2'b00};
        2, 3:    t_r = 32'h3F0 + 32'(4 * $urandom_range(0, 3));
        default: t_r = {22'h0, 8'($urandom), 2'b00};
      endcase
      cycle(s_r, r_r, t_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
